// File: rtl/global_memory_responder_pkg.sv
// Shared types and constants for the global memory responder.
// No logic here; enums, the address width and a compile-time clog2 helper.
// Has no handshake of its own.
package mem_pkg;

    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD
    } state_t;

    typedef enum logic {
        READ_REQ,
        WRITE_REQ
    } req_kind_t;

    // Ceiling log2 for sizing the array index from DEPTH.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/global_memory_responder_if.sv
// Load/store bus between a processing block and the memory responder.
// Pure wiring; all timing is set by the responder.
// Requester holds ctrl levels; the responder signals busy and load_valid.
interface global_memory_responder_if #(
    parameter int W = 512
);
    logic                       load_ctrl;
    logic [mem_pkg::ADDR_W-1:0] load_addr;
    logic                       write_ctrl;
    logic [mem_pkg::ADDR_W-1:0] write_addr_main;
    logic [W-1:0]               write_data_main;
    logic [W-1:0]               load_data;
    logic                       load_valid;
    logic                       busy;
    logic                       addr_error;
    logic                       proto_error;

    modport master (
        output load_ctrl, load_addr, write_ctrl, write_addr_main, write_data_main,
        input  load_data, load_valid, busy, addr_error, proto_error
    );

    modport slave (
        input  load_ctrl, load_addr, write_ctrl, write_addr_main, write_data_main,
        output load_data, load_valid, busy, addr_error, proto_error
    );
endinterface

// File: rtl/global_memory_responder_vector_mem_array.sv
// Single-port DEPTH x W synchronous RAM with registered read.
// Latency: write commits at the edge; read data valid one cycle after re.
// No backpressure; read data holds when re is low.
module vector_mem_array #(
    parameter int W     = 512,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clock,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    // Storage port: contents survive reset, so no reset branch here.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/global_memory_responder.sv
// Memory-side responder: accepts held load/store levels, services one at a time.
// Latency: load_valid high in the cycle after edge N+READ_LATENCY (accept at N).
// Backpressure: busy while a read is in flight; HOLD suppresses re-issue of held requests.
module global_memory_responder
    import mem_pkg::*;
#(
    parameter int CORES        = 32,
    parameter int BITS         = 16,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    global_memory_responder_if.slave bus
);
    localparam int W     = CORES * BITS;
    localparam int AW    = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    // Range check uses the full 16-bit address, widened so DEPTH=65536 compares correctly.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    state_t              state_q, state_d;
    req_kind_t           kind_q, kind_d;
    logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]        load_data_q, load_data_d;
    logic                load_valid_q, load_valid_d;
    logic                busy_q, busy_d;
    logic                addr_err_q, addr_err_d;
    logic                proto_err_q, proto_err_d;

    logic                ram_we;
    logic                ram_re;
    logic [AW-1:0]       ram_addr;
    logic [W-1:0]        ram_rdata;
    logic                release_hold;

    vector_mem_array #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clock (clock),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (bus.write_data_main),
        .rdata (ram_rdata)
    );

    // Next-state, RAM port steering and output updates.
    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        hold_addr_d  = hold_addr_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        busy_d       = busy_q;
        addr_err_d   = addr_err_q;
        proto_err_d  = proto_err_q;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_addr     = bus.load_addr[AW-1:0];
        release_hold = 1'b0;

        if (bus.load_ctrl && bus.write_ctrl) begin
            proto_err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Write wins when both levels are high; the read is dropped.
                if (bus.write_ctrl) begin
                    ram_addr = bus.write_addr_main[AW-1:0];
                    if (in_range(bus.write_addr_main)) begin
                        ram_we = 1'b1;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                    kind_d      = WRITE_REQ;
                    hold_addr_d = bus.write_addr_main;
                    state_d     = HOLD;
                end else if (bus.load_ctrl) begin
                    // Fetch now; the registered read holds until the counter expires.
                    ram_re      = 1'b1;
                    kind_d      = READ_REQ;
                    hold_addr_d = bus.load_addr;
                    busy_d      = 1'b1;
                    cnt_d       = CNT_W'(READ_LATENCY - 1);
                    state_d     = READ;
                end
            end
            READ: begin
                if (cnt_q == '0) begin
                    if (in_range(hold_addr_q)) begin
                        load_data_d = ram_rdata;
                    end else begin
                        load_data_d = '0;
                        addr_err_d  = 1'b1;
                    end
                    load_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (kind_q == WRITE_REQ) begin
                    release_hold = !bus.write_ctrl || (bus.write_addr_main != hold_addr_q);
                end else begin
                    release_hold = !bus.load_ctrl || (bus.load_addr != hold_addr_q);
                end
                if (release_hold) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            kind_q       <= READ_REQ;
            hold_addr_q  <= '0;
            cnt_q        <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            addr_err_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            hold_addr_q  <= hold_addr_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            busy_q       <= busy_d;
            addr_err_q   <= addr_err_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign bus.load_data   = load_data_q;
    assign bus.load_valid  = load_valid_q;
    assign bus.busy        = busy_q;
    assign bus.addr_error  = addr_err_q;
    assign bus.proto_error = proto_err_q;
endmodule

// File: tb/tb_global_memory_responder.sv
// Bench for global_memory_responder: directed scenarios plus randomized traffic.
// Expected data comes from a transaction-level memory model kept here.
// Inputs driven 1ns after the rising edge; outputs sampled at the same point.
module tb_global_memory_responder;
    localparam int CORES = 32;
    localparam int BITS  = 16;
    localparam int DEPTH = 1024;
    localparam int L     = 2;
    localparam int W     = CORES * BITS;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] ref_mem [DEPTH];
    bit           written [DEPTH];

    global_memory_responder_if #(.W(W)) bus();

    global_memory_responder #(
        .CORES        (CORES),
        .BITS         (BITS),
        .DEPTH        (DEPTH),
        .READ_LATENCY (L)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] bcast(input logic [15:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < CORES; i++) r[i*BITS +: BITS] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [W-1:0] v);
        if (32'(a) < DEPTH) begin
            ref_mem[a] = v;
            written[a] = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_bus();
        bus.load_ctrl       = 1'b0;
        bus.write_ctrl      = 1'b0;
        bus.load_addr       = '0;
        bus.write_addr_main = '0;
        bus.write_data_main = '0;
    endtask

    task automatic do_reset();
        idle_bus();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        tick();
    endtask

    // Holds a request for 'hold' edges, observes 'window' cycles in total.
    task automatic run_req(input bit do_wr, input bit do_rd, input logic [15:0] addr,
                           input logic [W-1:0] data, input int hold, input int window,
                           output int pulses, output int first, output int busy_cnt,
                           output logic [W-1:0] last);
        pulses = 0; first = -1; busy_cnt = 0; last = '0;
        bus.write_ctrl      = do_wr;
        bus.load_ctrl       = do_rd;
        bus.write_addr_main = addr;
        bus.load_addr       = addr;
        bus.write_data_main = data;
        for (int i = 1; i <= window; i++) begin
            tick();
            if (bus.load_valid) begin
                pulses++;
                if (first < 0) first = i;
                last = bus.load_data;
            end
            if (bus.busy) busy_cnt++;
            if (i == hold) begin
                bus.write_ctrl = 1'b0;
                bus.load_ctrl  = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        idle_bus();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (bus.load_data !== '0) begin n_bad++; $display("FAIL reset_load_data got=%h want=0", bus.load_data); end
        n_cmp++; if (bus.load_valid !== 1'b0) begin n_bad++; $display("FAIL reset_load_valid got=%b want=0", bus.load_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        n_cmp++; if (bus.addr_error !== 1'b0) begin n_bad++; $display("FAIL reset_addr_error got=%b want=0", bus.addr_error); end
        n_cmp++; if (bus.proto_error !== 1'b0) begin n_bad++; $display("FAIL reset_proto_error got=%b want=0", bus.proto_error); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write_hold_read();
        int p, f, b;
        logic [W-1:0] d;
        // Held write with data changing mid-hold: only the first value lands.
        bus.write_ctrl      = 1'b1;
        bus.write_addr_main = 16'd5;
        bus.write_data_main = bcast(16'hABCD);
        tick();
        bus.write_data_main = bcast(16'h5555);
        tick();
        tick();
        bus.write_ctrl = 1'b0;
        tick();
        tick();
        model_write(16'd5, bcast(16'hABCD));
        run_req(1'b0, 1'b1, 16'd5, '0, 1, L + 5, p, f, b, d);
        n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL whr_pulses got=%0d want=1", p); end
        n_cmp++; if (f !== L + 1) begin n_bad++; $display("FAIL whr_latency got=%0d want=%0d", f - 1, L); end
        n_cmp++; if (b !== L) begin n_bad++; $display("FAIL whr_busy_cycles got=%0d want=%0d", b, L); end
        n_cmp++; if (d !== ref_mem[5]) begin n_bad++; $display("FAIL whr_data got=%h want=%h", d, ref_mem[5]); end
    endtask

    task automatic test_held_read();
        int p1, p2;
        logic [W-1:0] d1, d2, w7, w8;
        w7 = rand_word();
        w8 = rand_word();
        run_req(1'b1, 1'b0, 16'd7, w7, 1, 3, p1, p1, p1, d1);
        model_write(16'd7, w7);
        run_req(1'b1, 1'b0, 16'd8, w8, 1, 3, p1, p1, p1, d1);
        model_write(16'd8, w8);
        p1 = 0; p2 = 0; d1 = '0; d2 = '0;
        bus.load_ctrl = 1'b1;
        bus.load_addr = 16'd7;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.load_valid) begin p1++; d1 = bus.load_data; end
        end
        bus.load_addr = 16'd8;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.load_valid) begin p2++; d2 = bus.load_data; end
        end
        bus.load_ctrl = 1'b0;
        tick();
        tick();
        n_cmp++; if (p1 !== 1) begin n_bad++; $display("FAIL held_pulses_a7 got=%0d want=1", p1); end
        n_cmp++; if (d1 !== ref_mem[7]) begin n_bad++; $display("FAIL held_data_a7 got=%h want=%h", d1, ref_mem[7]); end
        n_cmp++; if (p2 !== 1) begin n_bad++; $display("FAIL held_pulses_a8 got=%0d want=1", p2); end
        n_cmp++; if (d2 !== ref_mem[8]) begin n_bad++; $display("FAIL held_data_a8 got=%h want=%h", d2, ref_mem[8]); end
    endtask

    task automatic test_proto();
        int p, f, b;
        logic [W-1:0] d;
        run_req(1'b1, 1'b1, 16'd3, bcast(16'h1111), 2, 6, p, f, b, d);
        model_write(16'd3, bcast(16'h1111));
        n_cmp++; if (p !== 0) begin n_bad++; $display("FAIL proto_no_valid got=%0d want=0", p); end
        n_cmp++; if (bus.proto_error !== 1'b1) begin n_bad++; $display("FAIL proto_error got=%b want=1", bus.proto_error); end
        run_req(1'b0, 1'b1, 16'd3, '0, 1, L + 4, p, f, b, d);
        n_cmp++; if (d !== ref_mem[3]) begin n_bad++; $display("FAIL proto_mem3 got=%h want=%h", d, ref_mem[3]); end
    endtask

    task automatic test_back_to_back();
        int p;
        logic [W-1:0] v, d;
        v = rand_word();
        p = 0; d = '0;
        bus.write_ctrl      = 1'b1;
        bus.write_addr_main = 16'd9;
        bus.write_data_main = v;
        tick();
        model_write(16'd9, v);
        bus.write_ctrl = 1'b0;
        bus.load_ctrl  = 1'b1;
        bus.load_addr  = 16'd9;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.load_valid) begin p++; d = bus.load_data; end
            if (i == 2) bus.load_ctrl = 1'b0;
        end
        n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL b2b_pulses got=%0d want=1", p); end
        n_cmp++; if (d !== ref_mem[9]) begin n_bad++; $display("FAIL b2b_data got=%h want=%h", d, ref_mem[9]); end
    endtask

    task automatic test_reset_mid_read();
        int p, f, b;
        logic [W-1:0] d;
        bus.load_ctrl = 1'b1;
        bus.load_addr = 16'd5;
        tick();
        bus.load_ctrl = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before got=%b want=1", bus.busy); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy_async got=%b want=0", bus.busy); end
        n_cmp++; if (bus.load_data !== '0) begin n_bad++; $display("FAIL midrst_data_async got=%h want=0", bus.load_data); end
        n_cmp++; if (bus.proto_error !== 1'b0) begin n_bad++; $display("FAIL midrst_proto got=%b want=0", bus.proto_error); end
        @(posedge clock);
        #1 reset = 1'b1;
        p = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.load_valid) p++;
        end
        n_cmp++; if (p !== 0) begin n_bad++; $display("FAIL midrst_no_valid got=%0d want=0", p); end
        run_req(1'b0, 1'b1, 16'd5, '0, 1, L + 4, p, f, b, d);
        n_cmp++; if (d !== ref_mem[5]) begin n_bad++; $display("FAIL midrst_mem5 got=%h want=%h", d, ref_mem[5]); end
    endtask

    task automatic test_addr_range();
        int p, f, b;
        logic [W-1:0] d, v, junk;
        n_cmp++; if (bus.addr_error !== 1'b0) begin n_bad++; $display("FAIL range_err_clear got=%b want=0", bus.addr_error); end
        run_req(1'b0, 1'b1, 16'd1024, '0, 1, L + 4, p, f, b, d);
        n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL range_pulses got=%0d want=1", p); end
        n_cmp++; if (d !== '0) begin n_bad++; $display("FAIL range_data got=%h want=0", d); end
        n_cmp++; if (bus.addr_error !== 1'b1) begin n_bad++; $display("FAIL range_err_set got=%b want=1", bus.addr_error); end
        // 2000 aliases to 976 in the low index bits; the write must be dropped.
        v = rand_word();
        junk = ~v;
        run_req(1'b1, 1'b0, 16'd976, v, 1, 3, p, f, b, d);
        model_write(16'd976, v);
        run_req(1'b1, 1'b0, 16'd2000, junk, 1, 3, p, f, b, d);
        model_write(16'd2000, junk);
        run_req(1'b0, 1'b1, 16'd976, '0, 1, L + 4, p, f, b, d);
        n_cmp++; if (d !== ref_mem[976]) begin n_bad++; $display("FAIL range_alias got=%h want=%h", d, ref_mem[976]); end
        n_cmp++; if (bus.addr_error !== 1'b1) begin n_bad++; $display("FAIL range_err_sticky got=%b want=1", bus.addr_error); end
    endtask

    task automatic test_random();
        int p, f, b, hold;
        bit any_oob;
        logic [15:0] a;
        logic [W-1:0] v, d;
        do_reset();
        any_oob = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(DEPTH, 65535));
            else a = 16'($urandom_range(0, 31));
            hold = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                v = rand_word();
                run_req(1'b1, 1'b0, a, v, hold, hold + 3, p, f, b, d);
                model_write(a, v);
                if (32'(a) >= DEPTH) any_oob = 1'b1;
                n_cmp++; if (p !== 0) begin n_bad++; $display("FAIL rnd_wr_valid op=%0d got=%0d want=0", n, p); end
            end else begin
                run_req(1'b0, 1'b1, a, '0, hold, hold + L + 4, p, f, b, d);
                n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL rnd_rd_pulses op=%0d got=%0d want=1", n, p); end
                n_cmp++; if (f !== L + 1) begin n_bad++; $display("FAIL rnd_rd_latency op=%0d got=%0d want=%0d", n, f - 1, L); end
                if (32'(a) >= DEPTH) begin
                    any_oob = 1'b1;
                    n_cmp++; if (d !== '0) begin n_bad++; $display("FAIL rnd_rd_oob op=%0d got=%h want=0", n, d); end
                end else if (written[a]) begin
                    n_cmp++; if (d !== ref_mem[a]) begin n_bad++; $display("FAIL rnd_rd_data op=%0d addr=%0d got=%h want=%h", n, a, d, ref_mem[a]); end
                end
            end
        end
        n_cmp++; if (bus.addr_error !== any_oob) begin n_bad++; $display("FAIL rnd_addr_error got=%b want=%b", bus.addr_error, any_oob); end
    endtask

    initial begin
        test_reset();
        test_write_hold_read();
        test_held_read();
        test_proto();
        test_back_to_back();
        test_reset_mid_read();
        test_addr_range();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
